// File: rtl/msx_wait_pkg.sv
// Shared types and helpers for the MSX Z80 wait-state generator.
// Bus cycle classes, FSM states and the per-class wait-count bundle.
package msx_wait_pkg;

    localparam int CNT_W_MAX = 8;

    typedef enum logic [1:0] {WC_M1, WC_MEM, WC_IO, WC_VDP} wait_class_t;

    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_EXT, ST_DONE} state_t;

    typedef struct packed {
        logic [CNT_W_MAX-1:0] m1;
        logic [CNT_W_MAX-1:0] mem;
        logic [CNT_W_MAX-1:0] io;
        logic [CNT_W_MAX-1:0] vdp;
    } wait_cfg_t;

    // Opcode fetch outranks plain memory, which outranks any I/O.
    function automatic wait_class_t classify(input logic mreq_n, input logic iorq_n,
                                             input logic m1_n, input logic vdp_sel);
        wait_class_t c;
        if (!m1_n && !mreq_n)
            c = WC_M1;
        else if (!mreq_n)
            c = WC_MEM;
        else if (!iorq_n && vdp_sel)
            c = WC_VDP;
        else
            c = WC_IO;
        return c;
    endfunction

    function automatic logic [CNT_W_MAX-1:0] class_count(input wait_cfg_t cfg,
                                                         input wait_class_t c);
        logic [CNT_W_MAX-1:0] n;
        unique case (c)
            WC_M1:   n = cfg.m1;
            WC_MEM:  n = cfg.mem;
            WC_IO:   n = cfg.io;
            WC_VDP:  n = cfg.vdp;
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/msx_wait_downcnt.sv
// Loadable down counter that stops at zero; all activity gated by a clock enable.
module msx_wait_downcnt
    import msx_wait_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ce) begin
            if (load)
                count <= load_val;
            else if (dec && (count != '0))
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/msx_wait_gen.sv
// Z80 wait-state generator: per-class programmable waits, VDP access spacing
// and a time-limited external wait, driving the T80 WAIT_n input.
module msx_wait_gen
    import msx_wait_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter int GAP_W          = 6,
    parameter int TO_W           = 8,
    parameter int EXWAIT_TIMEOUT = 255
) (
    input  logic              clk21m,
    input  logic              reset_n,
    input  logic              ce_3m58_p,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    input  logic              vdp_sel,
    input  logic              wait_en,
    input  logic [CNT_W-1:0]  wait_m1,
    input  logic [CNT_W-1:0]  wait_mem,
    input  logic [CNT_W-1:0]  wait_io,
    input  logic [CNT_W-1:0]  wait_vdp,
    input  logic [GAP_W-1:0]  vdp_gap,
    input  logic              exwait_n,
    input  logic              to_clr,
    output logic              wait_n,
    output wait_class_t       cls,
    output logic              timeout_flag
);

    localparam int NW = (CNT_W > GAP_W) ? CNT_W : GAP_W;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(EXWAIT_TIMEOUT);

    state_t            state, state_nxt;
    wait_class_t       cls_nxt, start_cls;
    wait_cfg_t         cfg;
    logic              wait_n_nxt;
    logic              start;
    logic [NW-1:0]     n_req;
    logic [NW-1:0]     cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              to_set;
    logic              cnt_load, cnt_dec;
    logic              gap_reload, gap_load, gap_dec;
    logic [GAP_W-1:0]  gap_load_val;

    assign start     = (~mreq_n & rfsh_n) | (~iorq_n & m1_n);
    assign start_cls = classify(mreq_n, iorq_n, m1_n, vdp_sel);

    always_comb begin
        cfg     = '0;
        cfg.m1  = CNT_W_MAX'(wait_m1);
        cfg.mem = CNT_W_MAX'(wait_mem);
        cfg.io  = CNT_W_MAX'(wait_io);
        cfg.vdp = CNT_W_MAX'(wait_vdp);
    end

    // A VDP access waits for whichever is longer: its own count or the leftover gap.
    always_comb begin
        n_req = '0;
        if (wait_en) begin
            n_req = NW'(class_count(cfg, start_cls));
            if ((start_cls == WC_VDP) && (NW'(gap_cnt) > n_req))
                n_req = NW'(gap_cnt);
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_n_nxt = wait_n;
        cls_nxt    = cls;
        to_cnt_nxt = to_cnt;
        to_set     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        gap_reload = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    cls_nxt = start_cls;
                    if ((n_req != '0) || !exwait_n) begin
                        state_nxt  = ST_COUNT;
                        wait_n_nxt = 1'b0;
                        cnt_load   = 1'b1;
                        to_cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_COUNT: begin
                cnt_dec = 1'b1;
                if (cnt <= NW'(1)) begin
                    if (exwait_n) begin
                        wait_n_nxt = 1'b1;
                        state_nxt  = ST_DONE;
                    end else begin
                        state_nxt = ST_EXT;
                    end
                end
            end
            ST_EXT: begin
                if (exwait_n) begin
                    wait_n_nxt = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                    if (to_cnt_nxt == TO_LIMIT) begin
                        wait_n_nxt = 1'b1;
                        state_nxt  = ST_DONE;
                        to_set     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                wait_n_nxt = 1'b1;
                if (mreq_n && iorq_n) begin
                    state_nxt  = ST_IDLE;
                    gap_reload = (cls == WC_VDP);
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                wait_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wait_n       <= 1'b1;
            cls          <= WC_M1;
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (ce_3m58_p) begin
            state  <= state_nxt;
            wait_n <= wait_n_nxt;
            cls    <= cls_nxt;
            to_cnt <= to_cnt_nxt;
            if (to_set)
                timeout_flag <= 1'b1;
            else if (to_clr)
                timeout_flag <= 1'b0;
        end
    end

    msx_wait_downcnt #(.W(NW)) u_cnt (
        .clk      (clk21m),
        .rst_n    (reset_n),
        .ce       (ce_3m58_p),
        .load     (cnt_load),
        .load_val (n_req),
        .dec      (cnt_dec),
        .count    (cnt)
    );

    // The gap only runs down while no VDP access is in flight; disabling waits pins it at zero.
    assign gap_load     = !wait_en || gap_reload;
    assign gap_load_val = wait_en ? vdp_gap : '0;
    assign gap_dec      = (state == ST_IDLE) || (cls != WC_VDP);

    msx_wait_downcnt #(.W(GAP_W)) u_gap (
        .clk      (clk21m),
        .rst_n    (reset_n),
        .ce       (ce_3m58_p),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (gap_dec),
        .count    (gap_cnt)
    );

endmodule

// File: tb/tb_msx_wait_gen.sv
// Self-checking bench for msx_wait_gen: directed scenarios then randomized bus
// cycles, compared against a transaction-level model of wait length and gap.
module tb_msx_wait_gen;
    import msx_wait_pkg::*;

    localparam int TIMEOUT = 255;
    localparam int K_M1 = 0, K_MEM = 1, K_IO = 2, K_VDP = 3, K_RFSH = 4, K_INTA = 5;

    logic        clk21m = 1'b0;
    logic        reset_n, ce_3m58_p;
    logic        mreq_n, iorq_n, m1_n, rfsh_n, vdp_sel, wait_en;
    logic [3:0]  wait_m1, wait_mem, wait_io, wait_vdp;
    logic [5:0]  vdp_gap;
    logic        exwait_n, to_clr;
    logic        wait_n;
    wait_class_t cls;
    logic        timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    int          tick_no    = 0;
    int          gap_load_m = 0;
    int          gap_end_m  = 0;
    bit          flag_m     = 1'b0;
    wait_class_t cls_m      = WC_M1;

    msx_wait_gen dut (
        .clk21m       (clk21m),
        .reset_n      (reset_n),
        .ce_3m58_p    (ce_3m58_p),
        .mreq_n       (mreq_n),
        .iorq_n       (iorq_n),
        .m1_n         (m1_n),
        .rfsh_n       (rfsh_n),
        .vdp_sel      (vdp_sel),
        .wait_en      (wait_en),
        .wait_m1      (wait_m1),
        .wait_mem     (wait_mem),
        .wait_io      (wait_io),
        .wait_vdp     (wait_vdp),
        .vdp_gap      (vdp_gap),
        .exwait_n     (exwait_n),
        .to_clr       (to_clr),
        .wait_n       (wait_n),
        .cls          (cls),
        .timeout_flag (timeout_flag)
    );

    always #5 clk21m = ~clk21m;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One ce tick, preceded by a random number of clocks with ce low; returns on a negedge.
    task automatic tick();
        int gaps;
        gaps = $urandom_range(0, 2);
        repeat (gaps) @(negedge clk21m);
        ce_3m58_p = 1'b1;
        @(negedge clk21m);
        ce_3m58_p = 1'b0;
        tick_no++;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1; vdp_sel = 1'b0;
    endtask

    task automatic bus_drive(input int kind);
        bus_idle();
        case (kind)
            K_M1:   begin mreq_n = 1'b0; m1_n = 1'b0; end
            K_MEM:  mreq_n = 1'b0;
            K_IO:   iorq_n = 1'b0;
            K_VDP:  begin iorq_n = 1'b0; vdp_sel = 1'b1; end
            K_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
            default: ;
        endcase
    endtask

    // Remaining VDP spacing at tick t: every tick after the last VDP end counts down.
    function automatic int gap_left(input int t);
        int r;
        r = gap_load_m - (t - gap_end_m - 1);
        return (r > 0) ? r : 0;
    endfunction

    // Runs one bus cycle; exwait_n is low for the first e_ticks ticks from the start tick.
    task automatic apply_stimulus(input int kind, input int e_ticks, input int idle_ticks,
                                  input bit scramble, output int lows);
        int          n, m, l, t0, lim;
        bit          to_exp;
        wait_class_t cls_exp;
        lows = 0;
        bus_idle();
        exwait_n = 1'b1;
        repeat (idle_ticks) tick();
        check_output("idle_wait_n", wait_n, 1'b1);
        if (!wait_en) gap_load_m = 0;
        t0 = tick_no + 1;
        bus_drive(kind);
        if (kind == K_RFSH || kind == K_INTA) begin
            for (int i = 0; i < 3; i++) begin
                exwait_n = (i < e_ticks) ? 1'b0 : 1'b1;
                tick();
                if (wait_n !== 1'b1) lows++;
            end
            check_output("nostart_len", lows, 0);
            check_output("nostart_cls", cls, cls_m);
            bus_idle();
            exwait_n = 1'b1;
            tick();
            return;
        end
        case (kind)
            K_M1:    begin n = wait_m1;  cls_exp = WC_M1;  end
            K_MEM:   begin n = wait_mem; cls_exp = WC_MEM; end
            K_IO:    begin n = wait_io;  cls_exp = WC_IO;  end
            default: begin
                n = (gap_left(t0) > int'(wait_vdp)) ? gap_left(t0) : int'(wait_vdp);
                cls_exp = WC_VDP;
            end
        endcase
        if (!wait_en) n = 0;
        m   = (n == 0) ? 1 : n;
        lim = (e_ticks < m + TIMEOUT) ? e_ticks : m + TIMEOUT;
        l   = (n == 0 && e_ticks == 0) ? 0 : ((lim > m) ? lim : m);
        to_exp = (l != 0) && (e_ticks > m + TIMEOUT);
        for (int i = 0; i <= l; i++) begin
            exwait_n = (i < e_ticks) ? 1'b0 : 1'b1;
            tick();
            if (wait_n !== 1'b1) lows++;
            if (i == 0 && scramble) begin
                wait_m1 = 4'($urandom); wait_mem = 4'($urandom);
                wait_io = 4'($urandom); wait_vdp = 4'($urandom);
            end
        end
        check_output("wait_len", lows, l);
        check_output("release", wait_n, 1'b1);
        check_output("cls", cls, cls_exp);
        bus_idle();
        exwait_n = 1'b1;
        tick();
        check_output("done_wait_n", wait_n, 1'b1);
        if (kind == K_VDP && wait_en) begin
            gap_load_m = vdp_gap;
            gap_end_m  = tick_no;
        end
        if (to_exp) flag_m = 1'b1;
        cls_m = cls_exp;
        check_output("timeout_flag", timeout_flag, flag_m);
    endtask

    initial begin
        int lows;
        int e;
        reset_n = 1'b0; ce_3m58_p = 1'b0; exwait_n = 1'b1; to_clr = 1'b0;
        bus_idle();
        wait_en = 1'b1; wait_m1 = 4'd1; wait_mem = 4'd0; wait_io = 4'd0; wait_vdp = 4'd0;
        vdp_gap = 6'd0;
        repeat (3) @(negedge clk21m);
        check_output("reset_wait_n", wait_n, 1'b1);
        check_output("reset_cls", cls, WC_M1);
        check_output("reset_flag", timeout_flag, 1'b0);
        reset_n = 1'b1;
        @(negedge clk21m);

        $display("[TB] default configuration");
        apply_stimulus(K_M1, 0, 2, 1'b0, lows);
        check_output("m1_one_wait", lows, 1);
        apply_stimulus(K_MEM, 0, 1, 1'b0, lows);
        check_output("mem_no_wait", lows, 0);
        apply_stimulus(K_IO, 0, 1, 1'b0, lows);
        check_output("io_no_wait", lows, 0);

        $display("[TB] refresh and interrupt acknowledge");
        wait_mem = 4'd3; wait_io = 4'd3;
        apply_stimulus(K_RFSH, 0, 1, 1'b0, lows);
        apply_stimulus(K_INTA, 2, 1, 1'b0, lows);

        $display("[TB] VDP spacing");
        wait_vdp = 4'd2; vdp_gap = 6'd10;
        apply_stimulus(K_VDP, 0, 1, 1'b0, lows);
        check_output("vdp_first", lows, 2);
        apply_stimulus(K_VDP, 0, 3, 1'b0, lows);
        check_output("vdp_second", lows, 7);

        $display("[TB] external wait");
        wait_mem = 4'd1;
        apply_stimulus(K_MEM, 5, 2, 1'b0, lows);
        check_output("exwait_len", lows, 5);
        check_output("exwait_noflag", timeout_flag, 1'b0);

        $display("[TB] external wait timeout");
        wait_m1 = 4'd1;
        apply_stimulus(K_M1, 1000, 1, 1'b0, lows);
        check_output("timeout_len", lows, 1 + TIMEOUT);
        check_output("timeout_set", timeout_flag, 1'b1);
        apply_stimulus(K_MEM, 0, 2, 1'b0, lows);
        check_output("timeout_sticky", timeout_flag, 1'b1);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        flag_m = 1'b0;
        check_output("timeout_clear", timeout_flag, 1'b0);

        $display("[TB] reset during a wait");
        wait_vdp = 4'd0; vdp_gap = 6'd20;
        apply_stimulus(K_VDP, 0, 1, 1'b0, lows);
        wait_mem = 4'd5;
        bus_drive(K_MEM);
        tick();
        tick();
        check_output("pre_reset_low", wait_n, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("async_reset_wait_n", wait_n, 1'b1);
        check_output("async_reset_cls", cls, WC_M1);
        bus_idle();
        @(negedge clk21m);
        reset_n = 1'b1;
        gap_load_m = 0; gap_end_m = tick_no; flag_m = 1'b0; cls_m = WC_M1;
        apply_stimulus(K_VDP, 0, 0, 1'b0, lows);
        check_output("fresh_gap", lows, 0);

        $display("[TB] randomized cycles");
        for (int c = 0; c < 40; c++) begin
            wait_m1  = 4'($urandom_range(0, 6));
            wait_mem = 4'($urandom_range(0, 6));
            wait_io  = 4'($urandom_range(0, 6));
            wait_vdp = 4'($urandom_range(0, 6));
            vdp_gap  = 6'($urandom_range(0, 20));
            wait_en  = ($urandom_range(0, 7) != 0);
            if (!wait_en) gap_load_m = 0;
            if ($urandom_range(0, 5) == 0) begin
                to_clr = 1'b1;
                tick();
                to_clr = 1'b0;
                flag_m = 1'b0;
            end
            e = $urandom_range(0, 9);
            if (e < 5) e = 0;
            else if (e < 9) e = $urandom_range(1, 8);
            else e = 300;
            apply_stimulus($urandom_range(0, 5), e, $urandom_range(0, 12),
                           1'($urandom_range(0, 1)), lows);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msx_wait_gen.md
Name: msx_wait_gen

Overview:
- Parametrised Z80 wait-state generator for the MSX core; replaces the fixed single M1 wait in the top level.
- Classifies each bus cycle as M1, MEM, IO or VDP and inserts a runtime-programmable number of wait states per class.
- Enforces a minimum spacing between consecutive VDP I/O accesses.
- Merges an external wait request, bounded by a timeout.
- Drives T80 WAIT_n; sits between the CPU strobes/IO decoder and the T80.

Parameters:
CNT_W, 4, width of per-class wait-count inputs (0..2^CNT_W-1 waits)
GAP_W, 6, width of VDP gap counter and vdp_gap input
TO_W, 8, width of external-wait timeout counter
EXWAIT_TIMEOUT, 255, ce ticks after which a held exwait_n is ignored for the rest of the cycle

Ports:
clk21m  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_3m58_p  in  1  CPU positive clock enable; all state advances only on it
mreq_n  in  1  CPU memory request
iorq_n  in  1  CPU I/O request
m1_n  in  1  CPU M1
rfsh_n  in  1  CPU refresh
vdp_sel  in  1  IO decoder: current I/O address is a VDP port
wait_en  in  1  0 = programmed waits and gap disabled, exwait only
wait_m1  in  CNT_W  waits for opcode fetch
wait_mem  in  CNT_W  waits for non-M1 memory
wait_io  in  CNT_W  waits for non-VDP I/O
wait_vdp  in  CNT_W  waits for VDP I/O
vdp_gap  in  GAP_W  minimum ce ticks between end of one VDP access and start of the next
exwait_n  in  1  external wait (cartridge), active low
to_clr  in  1  clears timeout_flag
wait_n  out  1  to T80 WAIT_n, registered
cls  out  2  class of current/last cycle (wait_class_t)
timeout_flag  out  1  sticky: an exwait timeout occurred

Behaviour:
- Reset (async, reset_n=0): wait_n=1, state IDLE, cls=WC_M1, timeout_flag=0, all counters 0. Applies immediately, including mid-cycle.
- Evaluation happens only on a ce_3m58_p tick. Between ticks all registers hold.
- Start detection, in IDLE:
  - Cycle starts when (~mreq_n & rfsh_n) | (~iorq_n & m1_n).
  - Refresh and interrupt-acknowledge (iorq_n=0 & m1_n=0) never start a cycle.
- Classification at start, priority order:
  - ~m1_n & ~mreq_n -> WC_M1
  - ~mreq_n -> WC_MEM
  - ~iorq_n & vdp_sel -> WC_VDP
  - else WC_IO
- Wait count N:
  - N = the class count when wait_en=1; 0 when wait_en=0.
  - For WC_VDP: N = max(wait_vdp, gap_cnt), zero-extended to max(CNT_W, GAP_W).
- States:
  - IDLE -> COUNT when start & (N>0 | ~exwait_n): wait_n<=0 on the same tick, cnt<=N.
  - IDLE -> DONE when start & N==0 & exwait_n: wait_n stays 1.
  - COUNT: cnt decrements each tick, stopping at 0. When cnt reaches 0 and exwait_n=1: wait_n<=1 -> DONE. If exwait_n=0 at that point -> EXT.
  - EXT: wait_n=0; to_cnt increments each tick. Exit to DONE with wait_n<=1 when exwait_n=1 or to_cnt==EXWAIT_TIMEOUT. On timeout, set timeout_flag.
  - DONE: wait_n=1 and exwait_n is ignored. DONE -> IDLE when mreq_n & iorq_n. On that transition, if cls==WC_VDP, gap_cnt<=vdp_gap.
- Waits are counted in ce ticks: N=1 gives exactly one tick with wait_n=0.
- gap_cnt: decrements each tick while >0 and state is IDLE or non-VDP. It is consumed as above, then reloaded at the end of each VDP cycle. If wait_en=0, gap_cnt is held at 0.
- to_cnt is cleared on entering COUNT.
- timeout_flag: to_clr clears it; set has priority over a simultaneous clear.
- Config inputs are sampled only at cycle start; changes mid-cycle do not affect the current cycle.
- Strobes released during COUNT/EXT (abnormal): finish the count, then go through DONE to IDLE normally.

Decomposition:
- Package msx_wait_pkg:
  - typedef enum logic [1:0] wait_class_t {WC_M1, WC_MEM, WC_IO, WC_VDP}
  - typedef enum state_t {ST_IDLE, ST_COUNT, ST_EXT, ST_DONE}
  - a packed struct grouping the four wait counts, for top-level config wiring
- One natural sub-module, msx_wait_downcnt: loadable, saturating-at-0 down counter with enable. Instanced for cnt and gap_cnt.

Test Plan:
- Default config (wait_m1=1, others 0), opcode fetch -> wait_n low for exactly 1 ce tick after the MREQ/M1 tick; memory read and I/O -> wait_n never low.
- wait_vdp=2, vdp_gap=10, two VDP OUTs whose cycles are separated by 3 ce ticks -> first access waits 2 ticks, second waits max(2, 10-3)=7 ticks.
- exwait_n held low 5 ticks during a wait_mem=1 cycle -> wait_n low from start until the tick exwait_n rises; timeout_flag stays 0.
- exwait_n stuck low, EXWAIT_TIMEOUT=255 -> wait_n released after 1+255 ticks; timeout_flag=1, and stays 1 until to_clr.
- Refresh (rfsh_n=0, mreq_n=0) and INTA (iorq_n=0, m1_n=0), with wait_mem=wait_io=3 -> wait_n stays 1.
- reset_n asserted in COUNT with cnt=5 -> wait_n=1 immediately (no clock edge); after release, the next cycle behaves as fresh with gap_cnt=0.
